// File: rtl/beat_seq_ctrl.sv
// Beat generator and shared memory-port sequencer for the multi-cycle CPU.
// Produces the one-hot beats t0..t3. The memory port goes to instruction fetch
// in t1 or to data access in t3, and the beat is held while memory stalls.
// The block also handles run/halt control, a wait-state timeout that stops the
// machine for good, and a retired-instruction counter.
// All outputs decode registers only. Each grant is decided on the edge that
// enters its beat, so it is valid for the whole first cycle of that beat.
module beat_seq_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             halt_req_i,
    input  logic             irr_i,
    input  logic             dm_req_i,
    input  logic             dm_we_i,
    input  logic             mem_rdy_i,
    output logic             t0_o,
    output logic             t1_o,
    output logic             t2_o,
    output logic             t3_o,
    output logic             if_gnt_o,
    output logic             dm_gnt_o,
    output logic             mem_en_o,
    output logic             mem_we_o,
    output logic             halted_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] icount_o
);

    // The wait counter only needs to count up to MAX_WAIT-1.
    localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    // If a stall arrives while this many stalls are already counted, the
    // count reaches MAX_WAIT-1 and the access is abandoned.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_HALT
    } state_e;

    state_e            state_q, state_d;
    logic              if_gnt_q, if_gnt_d;
    logic              dm_gnt_q, dm_gnt_d;
    logic              dm_we_q, dm_we_d;
    logic              halt_pend_q, halt_pend_d;
    logic              bus_err_q, bus_err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  icount_q, icount_d;

    logic stall;
    logic timeout;

    // mem_rdy only has meaning while a grant is active.
    assign stall   = (if_gnt_q | dm_gnt_q) & ~mem_rdy_i;
    assign timeout = stall & (wait_q == WAIT_LAST);

    // State register and all control flops, async active-low clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            halt_pend_q <= 1'b0;
            bus_err_q   <= 1'b0;
            wait_q      <= '0;
            icount_q    <= '0;
        end else begin
            state_q     <= state_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            dm_we_q     <= dm_we_d;
            halt_pend_q <= halt_pend_d;
            bus_err_q   <= bus_err_d;
            wait_q      <= wait_d;
            icount_q    <= icount_d;
        end
    end

    // Next-state logic. Grants live for one beat only, and the wait counter
    // is zero whenever no stall is in progress.
    always_comb begin
        state_d     = state_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        dm_we_d     = 1'b0;
        wait_d      = '0;
        halt_pend_d = halt_pend_q;
        bus_err_d   = bus_err_q;
        icount_d    = icount_q;

        if (halt_req_i && (state_q != S_HALT)) begin
            halt_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_T0;
                end
            end
            S_T0: begin
                state_d  = S_T1;
                if_gnt_d = irr_i;
            end
            S_T1: begin
                if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else if (stall) begin
                    wait_d   = wait_q + WAIT_W'(1);
                    if_gnt_d = 1'b1;
                end else begin
                    state_d = S_T2;
                end
            end
            S_T2: begin
                state_d  = S_T3;
                dm_gnt_d = dm_req_i;
                dm_we_d  = dm_req_i & dm_we_i;
            end
            S_T3: begin
                if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else if (stall) begin
                    wait_d   = wait_q + WAIT_W'(1);
                    dm_gnt_d = 1'b1;
                    dm_we_d  = dm_we_q;
                end else begin
                    icount_d = icount_q + CNT_W'(1);
                    if (halt_pend_q || halt_req_i) begin
                        state_d = S_HALT;
                    end else if (!run_i) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_T0;
                    end
                end
            end
            S_HALT: begin
                // A bus error makes HALT terminal until reset.
                if (!bus_err_q && run_i && !halt_req_i) begin
                    state_d = S_T0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The halt request has been honoured once HALT is entered.
        if ((state_d == S_HALT) && (state_q != S_HALT)) begin
            halt_pend_d = 1'b0;
        end
    end

    assign t0_o      = (state_q == S_T0);
    assign t1_o      = (state_q == S_T1);
    assign t2_o      = (state_q == S_T2);
    assign t3_o      = (state_q == S_T3);
    assign if_gnt_o  = if_gnt_q;
    assign dm_gnt_o  = dm_gnt_q;
    assign mem_en_o  = if_gnt_q | dm_gnt_q;
    assign mem_we_o  = dm_gnt_q & dm_we_q;
    assign halted_o  = (state_q == S_HALT);
    assign bus_err_o = bus_err_q;
    assign icount_o  = icount_q;

endmodule

// File: tb/tb_beat_seq_ctrl.sv
// Bench for beat_seq_ctrl. Each instruction is planned up front: the grant
// flags, the number of wait states, the halt pulse and the run level. The plan
// is turned into the inputs for every cycle and the outputs expected in that
// cycle. Beat timing comes from the instruction-length rule (4 + waits), the
// timeout limit (MAX_WAIT-1 stalls) and the end-of-instruction rules
// (halt, idle or continue).
module tb_beat_seq_ctrl;

    localparam int MW = 5;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic run = 1'b0, halt_req = 1'b0, irr = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_rdy = 1'b0;
    logic t0, t1, t2, t3, if_gnt, dm_gnt, mem_en, mem_we, halted, bus_err;
    logic [CW-1:0] icount;

    always #5 clk = ~clk;

    beat_seq_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .run_i(run), .halt_req_i(halt_req),
        .irr_i(irr), .dm_req_i(dm_req), .dm_we_i(dm_we), .mem_rdy_i(mem_rdy),
        .t0_o(t0), .t1_o(t1), .t2_o(t2), .t3_o(t3),
        .if_gnt_o(if_gnt), .dm_gnt_o(dm_gnt), .mem_en_o(mem_en), .mem_we_o(mem_we),
        .halted_o(halted), .bus_err_o(bus_err), .icount_o(icount)
    );

    typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_instr = 0;
    int    icount_m = 0;
    logic  bus_err_m = 1'b0;
    mode_t mode_m = M_IDLE;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (beats t3..t0|if|dm|en|we|halted|err|icount)",
                     tag, obs, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] obs_now();
        return {6'b0, t3, t2, t1, t0, if_gnt, dm_gnt, mem_en, mem_we, halted, bus_err, 16'(icount)};
    endfunction

    // One clock cycle: check the outputs expected in this cycle, then drive
    // the inputs that the next rising edge will sample.
    task automatic step(input string tag, input logic [3:0] beats, input logic ig, input logic dg,
                        input logic we, input logic hl, input logic rdy, input logic run_v,
                        input logic hr_v, input logic irr_v, input logic dmr_v, input logic dwe_v);
        logic [31:0] e;
        @(negedge clk);
        e = {6'b0, beats, ig, dg, ig | dg, dg & we, hl, bus_err_m, 16'(icount_m)};
        check_eq(tag, obs_now(), e);
        mem_rdy  = rdy;
        run      = run_v;
        halt_req = hr_v;
        irr      = irr_v;
        dm_req   = dmr_v;
        dm_we    = dwe_v;
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        icount_m  = 0;
        bus_err_m = 1'b0;
        mode_m    = M_IDLE;
        check_eq(tag, obs_now(), 32'h0);
        run = 1'b0; halt_req = 1'b0; irr = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One instruction, with the DUT expected in T0 at the first cycle.
    // fw and dw are the number of cycles memory holds mem_rdy low.
    task automatic instr(input logic ir, input logic dr, input logic we, input int fw, input int dw,
                         input int hr_at, input logic rand_run, input logic rst_t3);
        int   c;
        logic hp, rv, hv;
        string res;
        c = 0; hp = 1'b0; rv = 1'b1;
        n_instr++;
        // t0
        rv = rand_run ? ($urandom_range(0, 3) != 0) : 1'b1;
        hv = (c == hr_at); hp |= hv;
        step("t0", 4'b0001, 0, 0, 0, 0, rb(), rv, hv, ir, rb(), rb());
        c++;
        // t1
        if (ir) begin
            for (int k = 0; k <= fw; k++) begin
                rv = rand_run ? ($urandom_range(0, 3) != 0) : 1'b1;
                hv = (c == hr_at); hp |= hv;
                step("t1.fetch", 4'b0010, 1, 0, 0, 0, (k == fw), rv, hv, ir, rb(), rb());
                c++;
                if ((k + 1 == MW - 1) && (k < fw)) begin
                    bus_err_m = 1'b1; mode_m = M_HALT;
                    $display("instr %0d: fetch timeout after %0d stalls -> HALT bus_err icount=%0d",
                             n_instr, k + 1, icount_m);
                    return;
                end
            end
        end else begin
            rv = rand_run ? ($urandom_range(0, 3) != 0) : 1'b1;
            hv = (c == hr_at); hp |= hv;
            step("t1", 4'b0010, 0, 0, 0, 0, rb(), rv, hv, ir, rb(), rb());
            c++;
        end
        // t2
        rv = rand_run ? ($urandom_range(0, 3) != 0) : 1'b1;
        hv = (c == hr_at); hp |= hv;
        step("t2", 4'b0100, 0, 0, 0, 0, rb(), rv, hv, rb(), dr, we);
        c++;
        // t3
        if (dr) begin
            for (int k = 0; k <= dw; k++) begin
                rv = rand_run ? ($urandom_range(0, 3) != 0) : 1'b1;
                hv = (c == hr_at); hp |= hv;
                step("t3.data", 4'b1000, 0, 1, we, 0, (k == dw), rv, hv, rb(), dr, we);
                c++;
                if (rst_t3) begin
                    apply_reset("rst.mid_t3");
                    $display("instr %0d: reset asserted in t3 -> IDLE", n_instr);
                    return;
                end
                if ((k + 1 == MW - 1) && (k < dw)) begin
                    bus_err_m = 1'b1; mode_m = M_HALT;
                    $display("instr %0d: data timeout after %0d stalls -> HALT bus_err icount=%0d",
                             n_instr, k + 1, icount_m);
                    return;
                end
            end
        end else begin
            rv = rand_run ? ($urandom_range(0, 3) != 0) : 1'b1;
            hv = (c == hr_at); hp |= hv;
            step("t3", 4'b1000, 0, 0, 0, 0, rb(), rv, hv, rb(), dr, we);
            c++;
            if (rst_t3) begin
                apply_reset("rst.mid_t3");
                $display("instr %0d: reset asserted in t3 -> IDLE", n_instr);
                return;
            end
        end
        icount_m = (icount_m + 1) % (1 << CW);
        if (hp) begin
            mode_m = M_HALT; res = "HALT";
        end else if (!rv) begin
            mode_m = M_IDLE; res = "IDLE";
        end else begin
            mode_m = M_RUN; res = "T0";
        end
        $display("instr %0d: irr=%0d fw=%0d dm=%0d we=%0d dw=%0d halt_at=%0d len=%0d -> %s icount=%0d",
                 n_instr, ir, ir ? fw : 0, dr, we, dr ? dw : 0, hr_at, c, res, icount_m);
    endtask

    task automatic idle_phase();
        int n;
        logic rv;
        n = $urandom_range(0, 3);
        for (int k = 0; k <= n; k++) begin
            rv = (k == n) ? 1'b1 : rb();
            step("idle", 4'b0000, 0, 0, 0, 0, rb(), rv, 0, rb(), rb(), rb());
            if (rv) begin
                mode_m = M_RUN;
                break;
            end
        end
    endtask

    task automatic halt_phase();
        int n;
        logic rv, hv;
        if (bus_err_m) begin
            // Terminal: toggling run must not restart the machine.
            for (int k = 0; k < 4; k++) begin
                step("halt.err", 4'b0000, 0, 0, 0, 1, rb(), (k % 2 == 0), 0, rb(), rb(), rb());
            end
            step("halt.err", 4'b0000, 0, 0, 0, 1, rb(), 1, 0, rb(), rb(), rb());
            apply_reset("rst.after_err");
        end else begin
            n = $urandom_range(0, 3);
            for (int k = 0; k <= n; k++) begin
                rv = (k == n) ? 1'b1 : rb();
                hv = (k == n) ? 1'b0 : rb();
                step("halt", 4'b0000, 0, 0, 0, 1, rb(), rv, hv, rb(), rb(), rb());
                if (rv && !hv) begin
                    mode_m = M_RUN;
                    break;
                end
            end
        end
    endtask

    function automatic int pick_wait();
        return ($urandom_range(0, 19) == 0) ? MW - 1 : int'($urandom_range(0, MW - 2));
    endfunction

    initial begin
        #3;
        // Reset and idle with run low.
        apply_reset("reset");
        for (int k = 0; k < 5; k++) step("idle.run0", 4'b0000, 0, 0, 0, 0, rb(), 0, 0, rb(), rb(), rb());
        step("idle.go", 4'b0000, 0, 0, 0, 0, rb(), 1, 0, rb(), rb(), rb());
        mode_m = M_RUN;
        // Three zero-wait instructions.
        repeat (3) instr(1, 0, 0, 0, 0, -1, 0, 0);
        // Fetch with 3 waits, data write with 2 waits.
        instr(1, 1, 1, 3, 2, -1, 0, 0);
        // Halt pulse during t1, then restart.
        instr(1, 0, 0, 0, 0, 1, 0, 0);
        step("halt.resume", 4'b0000, 0, 0, 0, 1, rb(), 1, 0, rb(), rb(), rb());
        mode_m = M_RUN;
        // Fetch timeout at the stall limit.
        instr(1, 0, 0, MW - 1, 0, -1, 0, 0);
        halt_phase();
        // Counter wrap: 16 retires with a 4-bit counter bring icount back to 0.
        step("idle.go", 4'b0000, 0, 0, 0, 0, rb(), 1, 0, rb(), rb(), rb());
        mode_m = M_RUN;
        repeat (16) instr(rb(), rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 2), -1, 0, 0);
        // Reset in the middle of t3.
        instr(1, 1, 0, 0, 1, -1, 0, 1);
        // Randomized instruction stream.
        for (int i = 0; i < 250; i++) begin
            case (mode_m)
                M_IDLE: idle_phase();
                M_HALT: halt_phase();
                default: instr(rb(), rb(), rb(), pick_wait(), pick_wait(),
                               ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1, 1, 0);
            endcase
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
        $fatal(1, "watchdog");
    end

endmodule
